// File: rtl/sha256_digest_reader.sv
// Captures a finished SHA-256 digest on the rising edge of the core's ready flag
// and streams it out as four 64-bit beats over a valid/ready handshake.
module sha256_digest_reader #(
   parameter int MSB_FIRST = 1,
   parameter int CNT_W     = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             hash_ready_i,
   input  logic [255:0]     hash_i,
   input  logic             clear_i,
   output logic [63:0]      dout_o,
   output logic             dout_valid_o,
   input  logic             dout_ready_i,
   output logic [1:0]       dout_idx_o,
   output logic             dout_last_o,
   output logic             busy_o,
   output logic             overrun_o,
   output logic [CNT_W-1:0] drop_cnt_o
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               ready_q;
   logic [255:0]       digest_q, digest_d;
   logic [1:0]         beat_q, beat_d;
   logic               overrun_q, overrun_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic               done;
   logic               xfer;
   logic               last_xfer;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   // Beat 0 is the most significant word when MSB_FIRST, matching hex-string order.
   function automatic logic [63:0] beat_sel(input logic [255:0] d, input logic [1:0] b);
      logic [1:0] k;
      k = (MSB_FIRST != 0) ? ~b : b;
      case (k)
         2'd0:    return d[63:0];
         2'd1:    return d[127:64];
         2'd2:    return d[191:128];
         default: return d[255:192];
      endcase
   endfunction

   assign done      = hash_ready_i & ~ready_q;
   assign xfer      = (state_q == SEND) & dout_ready_i;
   assign last_xfer = xfer & (beat_q == 2'd3);

   always_comb begin
      state_d    = state_q;
      digest_d   = digest_q;
      beat_d     = beat_q;
      overrun_d  = overrun_q;
      drop_cnt_d = drop_cnt_q;

      if (clear_i) begin
         overrun_d  = 1'b0;
         drop_cnt_d = '0;
      end

      case (state_q)
         IDLE: begin
            if (done) begin
               digest_d = hash_i;
               beat_d   = 2'd0;
               state_d  = SEND;
            end
         end
         default: begin
            if (last_xfer) begin
               beat_d = 2'd0;
               if (done) begin
                  digest_d = hash_i;
               end else begin
                  state_d = IDLE;
               end
            end else if (xfer) begin
               beat_d = beat_q + 2'd1;
            end
            // A completion that cannot be handed straight over is lost; a drop
            // takes priority over a simultaneous clear.
            if (done && !last_xfer) begin
               overrun_d  = 1'b1;
               drop_cnt_d = sat_inc(clear_i ? '0 : drop_cnt_q);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         ready_q    <= 1'b1;
         digest_q   <= '0;
         beat_q     <= 2'd0;
         overrun_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= hash_ready_i;
         digest_q   <= digest_d;
         beat_q     <= beat_d;
         overrun_q  <= overrun_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign dout_valid_o = (state_q == SEND);
   assign busy_o       = (state_q == SEND);
   assign dout_idx_o   = beat_q;
   assign dout_last_o  = (state_q == SEND) & (beat_q == 2'd3);
   assign dout_o       = beat_sel(digest_q, beat_q);
   assign overrun_o    = overrun_q;
   assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Directed bench for sha256_digest_reader: readout, backpressure, overrun,
// back-to-back capture, clear and reset, with an LSB-first instance alongside.
module tb_sha256_digest_reader;

   logic          clk;
   logic          rst_i;
   logic          hash_ready_i;
   logic [255:0]  hash_i;
   logic          clear_i;
   logic          dout_ready_i;

   logic [63:0]   dout_o;
   logic          dout_valid_o;
   logic [1:0]    dout_idx_o;
   logic          dout_last_o;
   logic          busy_o;
   logic          overrun_o;
   logic [7:0]    drop_cnt_o;

   logic [63:0]   l_dout;
   logic          l_valid;
   logic [1:0]    l_idx;
   logic          l_last;
   logic          l_busy;
   logic          l_overrun;
   logic [7:0]    l_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [255:0] H1 =
      256'h60f55acae84181f3c806cea59180bae64a82efa5b4fe44126362282af85077b2;
   localparam logic [255:0] H2 =
      256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;

   logic [63:0] h1b [4] = '{64'h60f55acae84181f3, 64'hc806cea59180bae6,
                            64'h4a82efa5b4fe4412, 64'h6362282af85077b2};
   logic [63:0] h2b [4] = '{64'h0123456789abcdef, 64'hfedcba9876543210,
                            64'h0f1e2d3c4b5a6978, 64'h8796a5b4c3d2e1f0};
   int pat [8] = '{0, 0, 1, 0, 1, 1, 0, 1};

   sha256_digest_reader #(.MSB_FIRST(1), .CNT_W(8)) dut (
      .clk_i(clk), .rst_i(rst_i), .hash_ready_i(hash_ready_i), .hash_i(hash_i),
      .clear_i(clear_i), .dout_o(dout_o), .dout_valid_o(dout_valid_o),
      .dout_ready_i(dout_ready_i), .dout_idx_o(dout_idx_o), .dout_last_o(dout_last_o),
      .busy_o(busy_o), .overrun_o(overrun_o), .drop_cnt_o(drop_cnt_o)
   );

   sha256_digest_reader #(.MSB_FIRST(0), .CNT_W(8)) dut_lsb (
      .clk_i(clk), .rst_i(rst_i), .hash_ready_i(hash_ready_i), .hash_i(hash_i),
      .clear_i(clear_i), .dout_o(l_dout), .dout_valid_o(l_valid),
      .dout_ready_i(dout_ready_i), .dout_idx_o(l_idx), .dout_last_o(l_last),
      .busy_o(l_busy), .overrun_o(l_overrun), .drop_cnt_o(l_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input string tag, input int k, input logic [63:0] exp);
      check_eq({tag, "_vld"},  dout_valid_o, 1);
      check_eq({tag, "_idx"},  dout_idx_o, 256'(k));
      check_eq({tag, "_data"}, dout_o, exp);
      check_eq({tag, "_last"}, dout_last_o, (k == 3) ? 1 : 0);
      check_eq({tag, "_busy"}, busy_o, 1);
   endtask

   task automatic expect_idle(input string tag);
      check_eq({tag, "_vld"},  dout_valid_o, 0);
      check_eq({tag, "_busy"}, busy_o, 0);
      check_eq({tag, "_last"}, dout_last_o, 0);
   endtask

   // Fresh 0->1 edge on the ready flag; afterwards hash_i is scrambled.
   task automatic capture(input logic [255:0] h);
      hash_ready_i = 1'b0;
      tick();
      hash_ready_i = 1'b1;
      hash_i       = h;
      tick();
      hash_i       = ~h;
   endtask

   task automatic pulse_done(input logic [255:0] h);
      hash_ready_i = 1'b0;
      tick();
      hash_ready_i = 1'b1;
      hash_i       = h;
      tick();
   endtask

   initial begin
      int ei;
      rst_i        = 1'b1;
      hash_ready_i = 1'b1;
      hash_i       = '0;
      clear_i      = 1'b0;
      dout_ready_i = 1'b1;
      repeat (2) tick();
      expect_idle("rst");
      check_eq("rst_idx",  dout_idx_o, 0);
      check_eq("rst_dout", dout_o, 0);
      check_eq("rst_ovr",  overrun_o, 0);
      check_eq("rst_cnt",  drop_cnt_o, 0);

      // Basic readout; ready already high after reset must not capture.
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("no_false_cap", dout_valid_o, 0);
      end
      hash_ready_i = 1'b0;
      repeat (2) tick();
      hash_ready_i = 1'b1;
      hash_i       = H1;
      tick();
      hash_i       = '1;
      for (int k = 0; k < 4; k++) begin
         expect_beat("basic", k, h1b[k]);
         check_eq("lsb_data", l_dout, h1b[3-k]);
         tick();
      end
      expect_idle("basic_end");

      // Backpressure
      dout_ready_i = 1'b0;
      capture(H1);
      ei = 0;
      for (int i = 0; i < 8; i++) begin
         dout_ready_i = pat[i][0];
         expect_beat("bp", ei, h1b[ei]);
         tick();
         ei += pat[i];
      end
      expect_idle("bp_end");

      // Overrun during beat 1
      capture(H1);
      dout_ready_i = 1'b1;
      tick();
      dout_ready_i = 1'b0;
      pulse_done(H2);
      check_eq("ovr_flag", overrun_o, 1);
      check_eq("ovr_cnt",  drop_cnt_o, 1);
      dout_ready_i = 1'b1;
      for (int k = 1; k < 4; k++) begin
         expect_beat("ovr", k, h1b[k]);
         tick();
      end
      expect_idle("ovr_end");

      // Saturation: 1 + 300 drops
      dout_ready_i = 1'b0;
      capture(H1);
      for (int i = 0; i < 300; i++) begin
         pulse_done(H2);
         if (i == 9) check_eq("sat_mid", drop_cnt_o, 11);
      end
      check_eq("sat_cnt", drop_cnt_o, 255);
      check_eq("sat_ovr", overrun_o, 1);
      expect_beat("sat", 0, h1b[0]);
      dout_ready_i = 1'b1;
      repeat (4) tick();
      expect_idle("sat_end");

      // Clear
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check_eq("clr_ovr", overrun_o, 0);
      check_eq("clr_cnt", drop_cnt_o, 0);
      dout_ready_i = 1'b0;
      capture(H1);
      repeat (5) pulse_done(H2);
      check_eq("five_cnt", drop_cnt_o, 5);
      check_eq("five_ovr", overrun_o, 1);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check_eq("clr2_ovr", overrun_o, 0);
      check_eq("clr2_cnt", drop_cnt_o, 0);
      hash_ready_i = 1'b0;
      tick();
      hash_ready_i = 1'b1;
      hash_i       = H2;
      clear_i      = 1'b1;
      tick();
      clear_i = 1'b0;
      check_eq("clrdrop_ovr", overrun_o, 1);
      check_eq("clrdrop_cnt", drop_cnt_o, 1);

      // Back-to-back: completion coincides with beat-3 transfer
      dout_ready_i = 1'b1;
      repeat (2) tick();
      hash_ready_i = 1'b0;
      tick();
      expect_beat("b2b_pre", 3, h1b[3]);
      hash_ready_i = 1'b1;
      hash_i       = H2;
      tick();
      hash_i       = '0;
      check_eq("b2b_cnt", drop_cnt_o, 1);
      for (int k = 0; k < 4; k++) begin
         expect_beat("b2b", k, h2b[k]);
         tick();
      end
      expect_idle("b2b_end");

      // Reset during beat 2
      capture(H1);
      repeat (2) tick();
      expect_beat("mid", 2, h1b[2]);
      dout_ready_i = 1'b0;
      rst_i        = 1'b1;
      #1;
      expect_idle("async_rst");
      check_eq("async_ovr", overrun_o, 0);
      check_eq("async_cnt", drop_cnt_o, 0);
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("post_rst_quiet", dout_valid_o, 0);
      end
      capture(H1);
      expect_beat("post_rst", 0, h1b[0]);
      check_eq("post_rst_lsb", l_dout, 64'h6362282af85077b2);
      dout_ready_i = 1'b1;
      repeat (4) tick();
      expect_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
